// File: rtl/signal_conditioner.sv
// Input front-end: 2-FF synchroniser, glitch filter, edge pulse generator and stall (idle) detector.
// Latency: s sampled at edge k, held stable -> s_clean/pulse change at edge k+1+FILT_LEN.
// Backpressure: none; free-running strobes, no handshake.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   s         raw asynchronous input
//   edge_sel  00 rising, 01 falling, 10 both, 11 none
//   s_clean   synchronised, filtered level
//   pulse     one-cycle strobe per accepted edge matching edge_sel
//   glitch    one-cycle strobe when a pending level change is abandoned
//   idle      high while no transition has been accepted for >= TIMEOUT cycles
//   edge_cnt  saturating pulse count (only when EDGE_CNT_EN is defined)
//
// Optional feature macro: EDGE_CNT_EN (adds the edge_cnt port and counter).
module signal_conditioner #(
    parameter int FILT_LEN = 4,
    parameter int FILT_W   = 3,
    parameter int TIMEOUT  = 100_000_000,
    parameter int TO_W     = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s,
    input  logic [1:0]  edge_sel,
    output logic        s_clean,
    output logic        pulse,
    output logic        glitch,
    output logic        idle
`ifdef EDGE_CNT_EN
    ,
    output logic [15:0] edge_cnt
`endif
);

    logic              ff1;
    logic              ff2;
    logic [FILT_W-1:0] fcnt;
    logic [TO_W-1:0]   to_cnt;
    logic              accept;
    logic              edge_match;

    // A new level is taken once it has been seen on ff2 for FILT_LEN consecutive edges.
    assign accept = (ff2 != s_clean) && (fcnt == FILT_W'(FILT_LEN - 1));

    // ff2 is the level about to be accepted, so it tells rise (1) from fall (0).
    always_comb begin
        edge_match = 1'b0;
        case (edge_sel)
            2'b00:   edge_match = ff2;
            2'b01:   edge_match = ~ff2;
            2'b10:   edge_match = 1'b1;
            default: edge_match = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1     <= 1'b0;
            ff2     <= 1'b0;
            s_clean <= 1'b0;
            fcnt    <= '0;
            pulse   <= 1'b0;
            glitch  <= 1'b0;
            idle    <= 1'b0;
            to_cnt  <= '0;
        end else begin
            ff1 <= s;
            ff2 <= ff1;

            if (ff2 != s_clean) begin
                glitch <= 1'b0;
                if (accept) begin
                    s_clean <= ff2;
                    fcnt    <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else if (fcnt != '0) begin
                // Input fell back to the current level before the filter finished.
                fcnt   <= '0;
                glitch <= 1'b1;
            end else begin
                glitch <= 1'b0;
            end

            pulse <= accept && edge_match;

            // idle tracks the counter's next value so it rises in the same cycle
            // the counter reaches TIMEOUT; an accept always wins.
            if (accept) begin
                to_cnt <= '0;
                idle   <= 1'b0;
            end else if (to_cnt != TO_W'(TIMEOUT)) begin
                to_cnt <= to_cnt + 1'b1;
                idle   <= ((to_cnt + 1'b1) == TO_W'(TIMEOUT));
            end else begin
                idle <= 1'b1;
            end
        end
    end

`ifdef EDGE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (pulse && (edge_cnt != 16'hFFFF)) begin
            edge_cnt <= edge_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_signal_conditioner.sv
module tb_signal_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic        s;
    logic [1:0]  edge_sel;
    logic        s_clean;
    logic        pulse;
    logic        glitch;
    logic        idle;
`ifdef EDGE_CNT_EN
    logic [15:0] edge_cnt;
    logic        s1;
    logic        s_clean1;
    logic        pulse1;
    logic        glitch1;
    logic        idle1;
    logic [15:0] edge_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signal_conditioner #(
        .FILT_LEN(4), .FILT_W(3), .TIMEOUT(20), .TO_W(27)
    ) dut (
        .clk(clk), .rst(rst), .s(s), .edge_sel(edge_sel),
        .s_clean(s_clean), .pulse(pulse), .glitch(glitch), .idle(idle)
`ifdef EDGE_CNT_EN
        , .edge_cnt(edge_cnt)
`endif
    );

`ifdef EDGE_CNT_EN
    signal_conditioner #(
        .FILT_LEN(1), .FILT_W(1), .TIMEOUT(20), .TO_W(27)
    ) dut1 (
        .clk(clk), .rst(rst), .s(s1), .edge_sel(2'b10),
        .s_clean(s_clean1), .pulse(pulse1), .glitch(glitch1), .idle(idle1),
        .edge_cnt(edge_cnt1)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a square wave (10 high / 10 low) and tallies pulses and s_clean changes.
    task automatic square(input int periods, output int pulses, output int bad_rise,
                          output int trans);
        logic prev;
        pulses = 0; bad_rise = 0; trans = 0;
        prev = s_clean;
        for (int i = 0; i < periods * 20 + 8; i++) begin
            @(negedge clk);
            if (pulse) pulses++;
            if (pulse && !s_clean) bad_rise++;
            if (s_clean != prev) trans++;
            prev = s_clean;
            s = (i < periods * 20) && ((i % 20) < 10);
        end
    endtask

    initial begin
        int pc, bad, tr, gc, hi;

        // 1: reset with s high, then release and measure latency
        rst = 1'b1; s = 1'b1; edge_sel = 2'b00;
`ifdef EDGE_CNT_EN
        s1 = 1'b0;
`endif
        step(2);
        check("rst_s_clean", s_clean, 0);
        check("rst_pulse",   pulse,   0);
        check("rst_glitch",  glitch,  0);
        check("rst_idle",    idle,    0);
        rst = 1'b0;                    // next posedge is edge 0
        step(5);                       // after edge 4
        check("lat_before", s_clean, 0);
        step(1);                       // after edge 5
        check("lat_s_clean", s_clean, 1);
        check("lat_pulse",   pulse,   1);
        step(1);
        check("pulse_one_cycle", pulse, 0);

        // falling edge with rising selection: no pulse
        s = 1'b0; pc = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (pulse) pc++;
        end
        check("fall_s_clean", s_clean, 0);
        check("fall_no_pulse", pc, 0);

        // 2: two-cycle high glitch with both edges selected
        edge_sel = 2'b10; s = 1'b1;
        step(2);
        s = 1'b0; gc = 0; pc = 0; hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (glitch) gc++;
            if (pulse) pc++;
            if (s_clean) hi++;
        end
        check("glitch_count",  gc, 1);
        check("glitch_pulse",  pc, 0);
        check("glitch_s_clean", hi, 0);

        // 3: square wave under each edge selection
        edge_sel = 2'b00;
        square(3, pc, bad, tr);
        check("sq_rise_pulses", pc, 3);
        check("sq_rise_on_rise", bad, 0);
        edge_sel = 2'b10;
        square(3, pc, bad, tr);
        check("sq_both_pulses", pc, 6);
        edge_sel = 2'b11;
        square(3, pc, bad, tr);
        check("sq_none_pulses", pc, 0);
        check("sq_none_tracks", tr, 6);

        // 4: idle timeout from reset, cleared by an accept, re-asserted
        s = 1'b0; edge_sel = 2'b00;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(19);
        check("idle_before", idle, 0);
        step(1);
        check("idle_at_timeout", idle, 1);
        s = 1'b1;
        step(5);
        check("idle_hold", idle, 1);
        step(1);
        check("idle_accept_sc", s_clean, 1);
        check("idle_cleared", idle, 0);
        step(19);
        check("idle_re_before", idle, 0);
        step(1);
        check("idle_re_assert", idle, 1);

        // 5: async reset mid-filter
        s = 1'b0;
        step(6);
        check("pre5_s_clean", s_clean, 0);
        s = 1'b1;
        step(4);                       // ff1 took s at edge k; now after edge k+3
        check("mid_fcnt", dut.fcnt, 2);
        rst = 1'b1;
        #1;
        check("async_fcnt", dut.fcnt, 0);
        check("async_s_clean", s_clean, 0);
        check("async_pulse", pulse, 0);
        step(1);
        rst = 1'b0;
        step(5);
        check("relat_before", s_clean, 0);
        step(1);
        check("relat_s_clean", s_clean, 1);
        check("relat_pulse", pulse, 1);

`ifdef EDGE_CNT_EN
        // 6: saturating edge counter, FILT_LEN=1, both edges
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            s1 = ~s1;
        end
        step(5);
        check("cnt_saturated", edge_cnt1, 16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s1 = ~s1;
        end
        step(5);
        check("cnt_no_wrap", edge_cnt1, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
